// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD display scanner: captures a 14-bit value, converts it with a
// sequential double-dabble engine, and time-multiplexes four 7-segment digits.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dato_valido,
  input  logic [13:0] dato,
  output logic        listo,
  output logic [2:0]  contador_actualizar,
  output logic [6:0]  segmentos
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic          listo_q, listo_d;
  logic [3:0]    iter_q, iter_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  // One double-dabble iteration: correct nibbles >= 5, then shift {bcd, bin} left.
  function automatic logic [29:0] dabble_step(input logic [15:0] bcd, input logic [13:0] bin);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return {adj[14:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (dato_valido && listo_q) begin
          bin_d      = dato;
          bcd_d      = 16'd0;
          iter_d     = 4'd0;
          ovf_pend_d = (dato > 14'd9999);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // listo is registered so it stays low while reset is held and rises one edge later.
    listo_d = (state_d == IDLE);
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      listo_q    <= 1'b0;
      iter_q     <= 4'd0;
      ovf_pend_q <= 1'b0;
      disp_q     <= 16'd0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      listo_q    <= listo_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  logic [3:0] nib;
  logic       blank;

  always_comb begin
    nib   = disp_q[4*idx_q +: 4];
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (disp_q[15:4] == 12'd0);
      2'd2:    blank = (disp_q[15:8] == 8'd0);
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    if (ovf_q)                   segmentos = 7'b0111111;
    else if (BLANK_ZEROS && blank) segmentos = 7'b1111111;
    else                         segmentos = seg7(nib);
  end

  assign listo               = listo_q;
  assign contador_actualizar = {1'b0, idx_q};

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner with a 4-cycle refresh slot.
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        dato_valido;
  logic [13:0] dato;
  logic        listo;
  logic [2:0]  contador_actualizar;
  logic [6:0]  segmentos;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111, SD = 7'b0111111;

  logic [6:0] cap [4];

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_ZEROS(1'b1)) dut (
    .clk(clk), .reset(reset), .dato_valido(dato_valido), .dato(dato),
    .listo(listo), .contador_actualizar(contador_actualizar), .segmentos(segmentos)
  );

  always #5 clk = ~clk;

  task automatic wait_listo(input string name);
    int guard = 0;
    @(negedge clk);
    while (listo !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (listo !== 1'b1) begin
      fails++;
      $display("FAIL %s_wait_listo: listo=%b required 1 within 40 cycles", name, listo);
    end
  endtask

  task automatic start(input logic [13:0] v);
    wait_listo("start");
    dato_valido = 1'b1;
    dato        = v;
    @(posedge clk);
    #1 dato_valido = 1'b0;
  endtask

  task automatic check_latency(input string name);
    bit bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (listo !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s_busy: listo went high before 15 cycles, required 0", name);
    end
    @(negedge clk);
    tests++;
    if (listo !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready: listo=%b required 1 after commit", name, listo);
    end
  endtask

  task automatic check_disp(input string name, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_s [4];
    bit bad_idx = 0;
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (contador_actualizar > 3'd3) bad_idx = 1;
      else cap[contador_actualizar[1:0]] = segmentos;
    end
    tests++;
    if (bad_idx) begin
      fails++;
      $display("FAIL %s_index_range: contador_actualizar exceeded 3", name);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cap[i] !== exp_s[i]) begin
        fails++;
        $display("FAIL %s_digit%0d: segmentos=%b required %b", name, i, cap[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dato_valido = 1'b0; dato = '0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (listo !== 1'b0 || contador_actualizar !== 3'd0) begin
        fails++;
        $display("FAIL reset_hold: listo=%b idx=%0d required 0/0", listo, contador_actualizar);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (listo !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_early: listo=%b required 0", listo);
    end
    @(negedge clk);
    tests++;
    if (listo !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: listo=%b required 1", listo);
    end
    check_disp("reset_disp", S0, SB, SB, SB);
  endtask

  task automatic test_convert();
    start(14'd1234);
    check_latency("c1234");
    check_disp("c1234", S4, S3, S2, S1);
  endtask

  task automatic test_back_to_back();
    start(14'd9999);
    check_latency("c9999");
    check_disp("c9999", S9, S9, S9, S9);
    start(14'd10000);
    check_latency("c10000");
    check_disp("c10000", SD, SD, SD, SD);
    start(14'd7);
    check_latency("c7");
    check_disp("c7", S7, SB, SB, SB);
  endtask

  task automatic test_ignore_busy();
    start(14'd321);
    @(posedge clk);
    #1 begin dato_valido = 1'b1; dato = 14'd55; end
    @(negedge clk);
    tests++;
    if (listo !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy_listo: listo=%b required 0", listo);
    end
    @(posedge clk);
    #1 dato_valido = 1'b0;
    wait_listo("ignore");
    check_disp("ignore", S1, S2, S3, SB);
  endtask

  task automatic test_refresh();
    logic [2:0] prev, expv;
    int guard = 0;
    int e;
    @(negedge clk);
    prev = contador_actualizar;
    while (contador_actualizar === prev && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (guard >= 20) begin
      fails++;
      $display("FAIL refresh_advance: index stuck at %0d, required change within 20 cycles", prev);
    end
    e = int'(contador_actualizar);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      expv = 3'((e + j / 4) % 4);
      tests++;
      if (contador_actualizar !== expv) begin
        fails++;
        $display("FAIL refresh_seq%0d: index=%0d required %0d", j, contador_actualizar, expv);
      end
    end
  endtask

  task automatic test_commit_on_advance();
    logic [6:0] tab [4];
    logic [2:0] prev, e, e3;
    int guard = 0;
    tab[0] = S7; tab[1] = S6; tab[2] = S5; tab[3] = S4;
    wait_listo("coa");
    prev = contador_actualizar;
    while (contador_actualizar === prev && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    e = contador_actualizar;
    dato_valido = 1'b1;
    dato        = 14'd4567;
    @(posedge clk);
    #1 dato_valido = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    e3 = (e + 3'd3) & 3'd3;
    tests++;
    if (contador_actualizar !== e3 || listo !== 1'b0) begin
      fails++;
      $display("FAIL coa_before: idx=%0d listo=%b required %0d/0", contador_actualizar, listo, e3);
    end
    @(negedge clk);
    tests++;
    if (contador_actualizar !== e || listo !== 1'b1) begin
      fails++;
      $display("FAIL coa_edge: idx=%0d listo=%b required %0d/1", contador_actualizar, listo, e);
    end
    tests++;
    if (segmentos !== tab[e[1:0]]) begin
      fails++;
      $display("FAIL coa_seg: segmentos=%b required %b", segmentos, tab[e[1:0]]);
    end
  endtask

  task automatic test_reset_mid();
    start(14'd8888);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (listo !== 1'b0) begin
      fails++;
      $display("FAIL rmid_hold: listo=%b required 0", listo);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (listo !== 1'b1) begin
      fails++;
      $display("FAIL rmid_release: listo=%b required 1", listo);
    end
    repeat (20) @(negedge clk);
    check_disp("rmid", S0, SB, SB, SB);
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_to_back();
    test_ignore_busy();
    test_refresh();
    test_commit_on_advance();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
